ws2812_unipolar_rz_decoder: RTL and testbench
=============================================

WS2812_UNIPOLAR_RZ_DECODER -- requirements
Module: ws2812_unipolar_rz_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the pulse and low-time counters.
REQ-002 Parameter HIGH_MIN, default 2: the shortest valid high time, in clk cycles.
REQ-003 Parameter BIT_THRESH, default 6: high times of BIT_THRESH cycles or more decode as 1; shorter ones decode as 0.
REQ-004 Parameter HIGH_MAX, default 11: the longest valid high time, in clk cycles.
REQ-005 Parameter RESET_CYCLES, default 500: line-low time that counts as a latch/reset (50 us at 10 MHz).
REQ-006 clk  input  1: single clock, rising edge.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 data_in  input  1: raw unipolar return-to-zero line, asynchronous to clk.
REQ-009 bit_valid  output  1: one-cycle strobe marking each decoded bit.
REQ-010 bit_data  output  1: value of the decoded bit; valid only while bit_valid is high.
REQ-011 pixel_valid  output  1: one-cycle strobe marking each completed 24-bit word.
REQ-012 pixel_data  output  24: last completed word in GRB order, first received bit in [23]; held until the next word completes.
REQ-013 frame_end  output  1: one-cycle strobe when a latch (reset-length low) is detected.
REQ-014 err  output  1: one-cycle strobe on a malformed pulse.

Function
REQ-015 data_in SHALL pass through a two-flop synchronizer; din_s denotes the second flop, and all decoding SHALL use din_s only.
REQ-016 The FSM states SHALL be WAIT_LATCH, LOW, HIGH and ERROR, with WAIT_LATCH as the reset state.
REQ-017 WAIT_LATCH and ERROR SHALL count consecutive din_s=0 cycles, clear the count when din_s=1, and go to LOW once the count reaches RESET_CYCLES; frame_end SHALL NOT pulse on this transition.
REQ-018 LOW SHALL count low cycles; on din_s=1 it SHALL go to HIGH with the high counter loaded to 1.
REQ-019 LOW SHALL pulse frame_end once when the low count reaches RESET_CYCLES, then stay in LOW with the count saturated.
REQ-020 HIGH SHALL increment the high counter each cycle that din_s=1; the counter SHALL saturate at its maximum value and never wrap.
REQ-021 HIGH SHALL go to ERROR and pulse err in the cycle after the count exceeds HIGH_MAX.
REQ-022 On din_s=0 in HIGH, with HIGH_MIN <= count <= HIGH_MAX, the FSM SHALL emit bit_data = (count >= BIT_THRESH), pulse bit_valid, and go to LOW with the low counter loaded to 1.
REQ-023 On din_s=0 in HIGH, with count < HIGH_MIN, the FSM SHALL pulse err, discard the bit, leave the bit index unchanged, and go to LOW.
REQ-024 bit_valid, err and frame_end SHALL be registered, asserting the cycle after the deciding clk edge; latency from the data_in edge to the strobe SHALL be 3 clk cycles.
REQ-025 Decoded bits SHALL shift into a 24-bit register MSB-first, with a 5-bit index counting 0..23.
REQ-026 The 24th bit SHALL, in the same cycle, load pixel_data, pulse pixel_valid together with bit_valid, and wrap the index to 0.
REQ-027 frame_end and entry to ERROR SHALL clear the index and discard any partial word; pixel_data SHALL be kept.
REQ-028 At most one of frame_end and err SHALL assert per cycle; bit_valid and err SHALL never assert together.
REQ-029 Strobes SHALL never be held for more than one cycle.

Reset
REQ-030 Asserting rst SHALL, without waiting for a clk edge, clear both synchronizer flops, all counters, the shift register and the index; set state to WAIT_LATCH; and drive every output to 0, including pixel_data = 24'h000000.
REQ-031 A pulse in progress when rst asserts SHALL be dropped; after release, decoding SHALL resume only after a full RESET_CYCLES low period.

Structure
REQ-032 A shared package ws2812_pkg SHALL hold the FSM state typedef and the default timing constants, which the encoder also uses.
REQ-033 The synchronizer SHALL be a separate sub-module, ws2812_sync2; all other logic SHALL be in one module.

Verification (clk = 100 ns)
REQ-034 Hold the line low 60 us, then send a 4-cycle high and 8-cycle low -> one bit_valid with bit_data=0, 3 cycles after the falling edge; no err.
REQ-035 After a latch, send 24 bits of 0xA5C31E (8-cycle high for 1, 4-cycle high for 0, 12-cycle period) -> 24 bit_valid strobes, then pixel_valid with pixel_data=24'hA5C31E.
REQ-036 Send 10 bits, hold low 60 us, then send 0x000001 -> frame_end once, and exactly one pixel_valid with 24'h000001.
REQ-037 Send a 1-cycle glitch high, then a 14-cycle high -> err for the glitch with no bit; err for the long pulse and state ERROR; no bit_valid until after a 500-cycle low.
REQ-038 Assert rst during bit 12 of a word -> all outputs 0 immediately; after release, the next frame decodes correctly only after 500 low cycles.
REQ-039 Send a pulse of exactly BIT_THRESH (6) cycles -> bit_data=1; a pulse of 5 cycles -> bit_data=0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 unipolar return-to-zero line codec.
//   ws2812_state_t   : decoder FSM state encoding (also exported as a debug port)
//   WS_*             : default timing constants in clk cycles, shared by the
//                      encoder and the decoder so both agree on the line format
// ----------------------------------------------------------------------------
package ws2812_pkg;

   typedef enum logic [1:0] {
      WAIT_LATCH = 2'd0,
      LOW        = 2'd1,
      HIGH       = 2'd2,
      ERROR      = 2'd3
   } ws2812_state_t;

   // Counter width used for both the high-time and the low-time counters.
   localparam int WS_CNT_W        = 16;

   // Decoder acceptance window for a high pulse, and the 0/1 decision point.
   localparam int WS_HIGH_MIN     = 2;
   localparam int WS_BIT_THRESH   = 6;
   localparam int WS_HIGH_MAX     = 11;

   // Low time that marks a latch (50 us at 10 MHz).
   localparam int WS_RESET_CYCLES = 500;

   // Nominal encoder waveform: 4-cycle high for a 0, 8-cycle high for a 1,
   // 12-cycle bit period.
   localparam int WS_T0H          = 4;
   localparam int WS_T1H          = 8;
   localparam int WS_TBIT         = 12;

   // One pixel is 24 bits, GRB order, first bit on the wire is the MSB.
   localparam int WS_PIXEL_BITS   = 24;

endpackage

// File: rtl/ws2812_sync2.sv
// ----------------------------------------------------------------------------
// ws2812_sync2
// Two-flop synchronizer bringing the asynchronous line into the clk domain.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears both flops
//   d    : asynchronous input
//   q    : synchronized output (second flop)
// ----------------------------------------------------------------------------
module ws2812_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ws2812_unipolar_rz_decoder.sv
// ----------------------------------------------------------------------------
// ws2812_unipolar_rz_decoder
// Decodes a WS2812-style unipolar return-to-zero line into bits and 24-bit
// GRB pixel words by measuring the high time of every pulse.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   data_in     : raw line, asynchronous to clk
//   bit_valid   : one-cycle strobe per decoded bit
//   bit_data    : decoded bit value, meaningful only with bit_valid
//   pixel_valid : one-cycle strobe per completed 24-bit word (with bit_valid)
//   pixel_data  : last completed word, first received bit in [23], held
//   frame_end   : one-cycle strobe when a latch-length low is seen
//   err         : one-cycle strobe on a malformed pulse
//   dbg_state   : current FSM state, for observation only
// All strobes are registered: they assert the cycle after the clk edge that
// decided them, i.e. 3 clk cycles after the data_in edge.
// ----------------------------------------------------------------------------
module ws2812_unipolar_rz_decoder
   import ws2812_pkg::*;
#(
   parameter int CNT_W        = WS_CNT_W,
   parameter int HIGH_MIN     = WS_HIGH_MIN,
   parameter int BIT_THRESH   = WS_BIT_THRESH,
   parameter int HIGH_MAX     = WS_HIGH_MAX,
   parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_in,
   output logic          bit_valid,
   output logic          bit_data,
   output logic          pixel_valid,
   output logic [23:0]   pixel_data,
   output logic          frame_end,
   output logic          err,
   output ws2812_state_t dbg_state
);

   localparam logic [CNT_W-1:0] HIGH_MIN_C   = CNT_W'(HIGH_MIN);
   localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] HIGH_MAX_C   = CNT_W'(HIGH_MAX);
   localparam logic [CNT_W-1:0] RESET_C      = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] RESET_M1_C   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX_C    = '1;
   localparam logic [4:0]       LAST_IDX_C   = 5'(WS_PIXEL_BITS - 1);

   // ------------------------------------------------------------------
   // Synchronized line; nothing below looks at data_in directly.
   // ------------------------------------------------------------------
   logic din_s;

   ws2812_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (data_in),
      .q   (din_s)
   );

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   ws2812_state_t    state_q, state_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;
   logic [23:0]      shift_q, shift_d;
   logic [4:0]       idx_q, idx_d;
   logic [23:0]      pixel_d;
   logic             bit_valid_d, bit_data_d, pixel_valid_d;
   logic             frame_end_d, err_d;

   // Decisions from the FSM handed to the word assembler.
   logic             take_bit;
   logic             new_bit;
   logic             clear_word;
   logic [23:0]      word;

   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= WAIT_LATCH;
         hcnt_q      <= '0;
         lcnt_q      <= '0;
         shift_q     <= '0;
         idx_q       <= '0;
         pixel_data  <= '0;
         bit_valid   <= 1'b0;
         bit_data    <= 1'b0;
         pixel_valid <= 1'b0;
         frame_end   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         lcnt_q      <= lcnt_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         pixel_data  <= pixel_d;
         bit_valid   <= bit_valid_d;
         bit_data    <= bit_data_d;
         pixel_valid <= pixel_valid_d;
         frame_end   <= frame_end_d;
         err         <= err_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      hcnt_d        = hcnt_q;
      lcnt_d        = lcnt_q;
      shift_d       = shift_q;
      idx_d         = idx_q;
      pixel_d       = pixel_data;
      bit_valid_d   = 1'b0;
      bit_data_d    = 1'b0;
      pixel_valid_d = 1'b0;
      frame_end_d   = 1'b0;
      err_d         = 1'b0;
      take_bit      = 1'b0;
      new_bit       = 1'b0;
      clear_word    = 1'b0;
      word          = '0;

      case (state_q)
         // Out of sync: wait for a full latch-length low before trusting
         // pulse boundaries. Entering LOW with the counter saturated means
         // this latch itself does not produce frame_end.
         WAIT_LATCH, ERROR: begin
            if (din_s) begin
               lcnt_d = '0;
            end else if (lcnt_q >= RESET_M1_C) begin
               state_d = LOW;
               lcnt_d  = RESET_C;
            end else begin
               lcnt_d = lcnt_q + ONE_C;
            end
         end

         LOW: begin
            if (din_s) begin
               state_d = HIGH;
               hcnt_d  = ONE_C;
            end else if (lcnt_q < RESET_C) begin
               lcnt_d = lcnt_q + ONE_C;
               // Fires exactly once: afterwards the count stays saturated.
               if (lcnt_q == RESET_M1_C) begin
                  frame_end_d = 1'b1;
                  clear_word  = 1'b1;
               end
            end
         end

         HIGH: begin
            if (hcnt_q > HIGH_MAX_C) begin
               // Pulse already too long: give up sync. The rest of the
               // pulse (if any) just keeps the latch counter cleared.
               state_d    = ERROR;
               err_d      = 1'b1;
               lcnt_d     = '0;
               clear_word = 1'b1;
            end else if (din_s) begin
               hcnt_d = (hcnt_q == CNT_MAX_C) ? hcnt_q : hcnt_q + ONE_C;
            end else begin
               state_d = LOW;
               lcnt_d  = ONE_C;
               if (hcnt_q < HIGH_MIN_C) begin
                  // Glitch: flag it but keep the partial word intact.
                  err_d = 1'b1;
               end else begin
                  take_bit = 1'b1;
                  new_bit  = (hcnt_q >= BIT_THRESH_C);
               end
            end
         end

         default: begin
            state_d = WAIT_LATCH;
            lcnt_d  = '0;
         end
      endcase

      // Word assembly: MSB-first shift, the 24th bit completes the pixel.
      if (clear_word) begin
         idx_d   = '0;
         shift_d = '0;
      end else if (take_bit) begin
         word        = {shift_q[22:0], new_bit};
         bit_valid_d = 1'b1;
         bit_data_d  = new_bit;
         shift_d     = word;
         if (idx_q == LAST_IDX_C) begin
            idx_d         = '0;
            pixel_d       = word;
            pixel_valid_d = 1'b1;
         end else begin
            idx_d = idx_q + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_unipolar_rz_decoder.sv
// ----------------------------------------------------------------------------
// tb_ws2812_unipolar_rz_decoder
// Drives the line as a sequence of (high time, low time) pulses. A pulse-level
// model turns each pulse into the events the decoder must produce (bit, pixel,
// frame_end, err); a monitor pops them from exp_q in order as the strobes
// appear.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_unipolar_rz_decoder;
   import ws2812_pkg::*;

   localparam int RC   = 500;
   localparam int HMIN = 2;
   localparam int BT   = 6;
   localparam int HMAX = 11;
   localparam int EW   = 27;

   localparam logic [2:0] EV_BIT = 3'd1;
   localparam logic [2:0] EV_PIX = 3'd2;
   localparam logic [2:0] EV_FE  = 3'd3;
   localparam logic [2:0] EV_ERR = 3'd4;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          data_in;
   logic          bit_valid, bit_data, pixel_valid, frame_end, err;
   logic [23:0]   pixel_data;
   ws2812_state_t dbg_state;

   always #50 clk = ~clk;

   ws2812_unipolar_rz_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .bit_valid   (bit_valid),
      .bit_data    (bit_data),
      .pixel_valid (pixel_valid),
      .pixel_data  (pixel_data),
      .frame_end   (frame_end),
      .err         (err),
      .dbg_state   (dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- pulse-level reference model ----------------
   logic [EW-1:0] exp_q[$];
   bit            m_synced = 1'b0;
   int            m_nbits  = 0;
   logic [23:0]   m_word   = '0;
   logic [23:0]   m_pix    = '0;

   function automatic logic [EW-1:0] ev(input logic [2:0] kind, input logic [23:0] d);
      return {kind, d};
   endfunction

   task automatic model_high(input int h);
      bit b;
      if (!m_synced) return;
      if (h < HMIN) begin
         exp_q.push_back(ev(EV_ERR, 24'd0));
      end else if (h <= HMAX) begin
         b = (h >= BT);
         exp_q.push_back(ev(EV_BIT, {23'd0, b}));
         m_word = {m_word[22:0], b};
         m_nbits++;
         if (m_nbits == 24) begin
            m_pix   = m_word;
            m_nbits = 0;
            exp_q.push_back(ev(EV_PIX, m_pix));
         end
      end else begin
         exp_q.push_back(ev(EV_ERR, 24'd0));
         m_synced = 1'b0;
         m_nbits  = 0;
         m_word   = '0;
      end
   endtask

   task automatic model_low(input int l);
      if (l >= RC) begin
         if (m_synced) begin
            exp_q.push_back(ev(EV_FE, 24'd0));
            m_nbits = 0;
            m_word  = '0;
         end
         m_synced = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_synced = 1'b0;
      m_nbits  = 0;
      m_word   = '0;
      m_pix    = '0;
   endtask

   // ---------------- driver tasks ----------------
   int cyc       = 0;
   int fall_cyc  = 0;
   bit lat_armed = 1'b0;

   task automatic drive_level(input logic v, input int n);
      @(negedge clk);
      data_in = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic send_low(input int l);
      model_low(l);
      drive_level(1'b0, l);
   endtask

   task automatic send_pulse(input int h, input int l, input bit arm = 1'b0);
      model_high(h);
      model_low(l);
      drive_level(1'b1, h);
      @(negedge clk);
      data_in   = 1'b0;
      fall_cyc  = cyc;
      lat_armed = arm;
      repeat (l - 1) @(negedge clk);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      int h;
      for (int i = 0; i < n; i++) begin
         h = w[23 - i] ? WS_T1H : WS_T0H;
         send_pulse(h, WS_TBIT - h);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic pop_check(input string tag, input logic [EW-1:0] got);
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(got), 32'd0);
      else                   check(tag, 32'(got), 32'(exp_q.pop_front()));
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         if (err) check("err_exclusive", {30'd0, bit_valid, frame_end}, 32'd0);
         if (bit_valid && lat_armed) begin
            check("bit_latency", 32'(cyc - fall_cyc), 32'd3);
            lat_armed = 1'b0;
         end
         if (bit_valid)   pop_check("bit", ev(EV_BIT, {23'd0, bit_data}));
         if (pixel_valid) pop_check("pixel", ev(EV_PIX, pixel_data));
         if (frame_end)   pop_check("frame_end", ev(EV_FE, 24'd0));
         if (err)         pop_check("err", ev(EV_ERR, 24'd0));
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_bit_valid"},   32'(bit_valid),   32'd0);
      check({tag, "_bit_data"},    32'(bit_data),    32'd0);
      check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
      check({tag, "_pixel_data"},  32'(pixel_data),  32'd0);
      check({tag, "_frame_end"},   32'(frame_end),   32'd0);
      check({tag, "_err"},         32'(err),         32'd0);
      check({tag, "_state"},       32'(dbg_state),   32'(WAIT_LATCH));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #8_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b1;
      data_in = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Sync with a 60 us low, then one short pulse -> a 0 bit, 3-cycle latency.
      send_low(600);
      check("state_after_latch", 32'(dbg_state), 32'(LOW));
      send_pulse(4, 8, 1'b1);

      // Full word after a latch.
      send_low(600);
      send_bits(24'hA5C31E, 24);
      repeat (4) @(negedge clk);
      check("pix_hold_a5c31e", 32'(pixel_data), 32'(m_pix));

      // Partial word dropped by a latch, then a fresh word.
      send_bits(24'hFFC000, 10);
      send_low(600);
      send_bits(24'h000001, 24);
      repeat (4) @(negedge clk);
      check("pix_hold_000001", 32'(pixel_data), 32'(m_pix));

      // Glitch, then an over-long pulse; ignored until a full latch.
      send_pulse(1, 8);
      send_pulse(14, 20);
      check("state_error", 32'(dbg_state), 32'(ERROR));
      send_pulse(8, 4);
      send_pulse(4, 8);
      send_low(600);
      send_bits(24'h5A3C96, 24);

      // Threshold boundaries: 6 -> 1, 5 -> 0, 2 -> 0, 11 -> 1, 12 -> err.
      send_pulse(BT, 6);
      send_pulse(BT - 1, 7);
      send_pulse(HMIN, 10);
      send_pulse(HMAX, 10);
      send_pulse(HMAX + 1, 600);

      // Reset in the middle of bit 12 of a word.
      send_bits(24'h123456, 11);
      @(negedge clk);
      data_in = 1'b1;
      repeat (3) @(negedge clk);
      #10;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_reset();
      data_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_pulse(8, 50);
      send_pulse(4, 100);
      send_low(600);
      send_bits(24'h3C5A96, 24);
      repeat (4) @(negedge clk);
      check("pix_after_reset", 32'(pixel_data), 32'(m_pix));

      // Randomized pulse train.
      for (int i = 0; i < 300; i++) begin
         int r, h, l;
         r = $urandom_range(0, 99);
         if (r < 6)       h = $urandom_range(12, 16);
         else if (r < 12) h = 1;
         else             h = $urandom_range(2, 11);
         r = $urandom_range(0, 99);
         l = (r < 6) ? $urandom_range(520, 600) : $urandom_range(3, 20);
         send_pulse(h, l);
      end

      send_low(30);
      repeat (10) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("pix_final", 32'(pixel_data), 32'(m_pix));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
